result_capture_buffer: RTL
==========================

# result_capture_buffer

Downstream stage of the adaptive rank-order filter. It discards the filter's pipeline-fill outputs, then captures a fixed-length run of valid filtered samples into on-chip RAM. Once capture finishes, it exposes a wrap-around read pointer that the debounced up/down buttons drive, so the stored results can be shown on the seven-segment displays.

## Interface
- DATA_BITS, 8, width of filtered sample
- DEPTH, 256, capture capacity in samples
- ADDR_BITS, 8, clog2(DEPTH)
- LATENCY, 46, filter fill outputs discarded before capture (N/2+1 for N=91)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  filter output valid this cycle
- in_data  in  DATA_BITS  filter output sample
- start  in  1  level; rising edge arms a new capture
- stop  in  1  level; ends capture early
- rd_inc  in  1  debounced button level; rising edge advances pointer
- rd_dec  in  1  debounced button level; rising edge retreats pointer
- rd_addr  out  ADDR_BITS  current read pointer
- rd_data  out  DATA_BITS  RAM contents at rd_addr, registered
- count  out  ADDR_BITS+1  samples captured
- busy  out  1  high in SKIP or CAPTURE
- done  out  1  high in DONE

## Operation
- FSM states: IDLE, SKIP, CAPTURE, DONE.
- Reset values: state IDLE; rd_addr 0; rd_data 0; count 0; busy 0; done 0; skip counter 0; edge-detect history 0.
- IDLE, start rising edge: clear count and skip counter, then go to SKIP. If LATENCY = 0, go directly to CAPTURE.
- SKIP:
  - Each in_valid increments the skip counter and the sample is discarded.
  - On the valid that brings the counter to LATENCY, go to CAPTURE.
  - stop here goes to DONE with count 0.
- CAPTURE:
  - Each in_valid writes in_data at address count, and count increments.
  - When count reaches DEPTH, go to DONE.
  - When stop is high, go to DONE. If in_valid is high in the same cycle, that sample is written first.
- DONE:
  - Entry sets rd_addr to 0.
  - A start rising edge restarts at SKIP. RAM is not cleared; stale data above count is unreachable.
- start edges seen in SKIP or CAPTURE are ignored.
- Read pointer (active only in DONE):
  - An inc edge gives rd_addr+1; at count−1 it wraps to 0.
  - A dec edge gives rd_addr−1; at 0 it wraps to count−1.
  - inc and dec edges in the same cycle: no change.
  - count = 0: rd_addr stays at 0.
- Edge detection: one-cycle history register per input. Inputs are already synchronous to clk.
- count saturates at DEPTH and is never incremented beyond it.

## Timing
- start is sampled on its rising edge; busy is high the following cycle.
- Write port is synchronous. A sample written at edge t is readable from edge t+1.
- rd_data updates one cycle after rd_addr changes (registered read).
- done rises in the cycle after the final write or after stop is sampled.
- Pointer moves one cycle after the button rising edge is seen.
- Reset mid-capture: immediate return to IDLE with all outputs at reset values. RAM contents are undefined afterwards.

## Structure
- Shared package holds:
  - State encoding constants: IDLE=0, SKIP=1, CAPTURE=2, DONE=3.
  - Default LATENCY derivation from filter N.
- Sub-module capture_ram: simple dual-port RAM with one synchronous write port, one registered read port, DEPTH×DATA_BITS, inferable as block RAM.
- Top body holds the FSM, counters, edge detectors and pointer logic.

## Test plan
- LATENCY=46, DEPTH=256, start edge, continuous in_valid with in_data = index mod 256 → first stored word is 46, done after 302 valids, count=256.
- Capture in progress, stop asserted with in_valid after 10 stored samples → count=11, done=1, last stored word is the sample presented with stop.
- DONE with count=5: three inc edges give rd_addr=3; one dec at 0 gives 4; inc at 4 gives 0; simultaneous inc+dec gives no change. Each rd_data matches the stored word one cycle later.
- Gapped in_valid (1 of 3 cycles) → only valid cycles count toward skip and capture; stored sequence identical to the continuous case.
- rst low during CAPTURE at count=100 → next edge: busy=0, count=0, rd_addr=0. A fresh start captures correctly.
- start edge during CAPTURE → ignored, count continues; count=0 case: inc/dec leave rd_addr=0.

Source files
------------

// File: rtl/result_capture_buffer_pkg.sv
// Shared definitions for the result capture buffer: state encoding and filter-derived latency.
`default_nettype none

package result_capture_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int FILTER_N = 91;

  // Outputs produced while the rank-order window is still filling.
  function automatic int latency_for_n(input int n);
    return n / 2 + 1;
  endfunction

  localparam int DEFAULT_LATENCY = latency_for_n(FILTER_N);

endpackage

`default_nettype wire

// File: rtl/result_capture_buffer_if.sv
// Filter-sample, control and read-back signal bundle for the result capture buffer.
`default_nettype none

interface result_capture_buffer_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 8
);

  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 start;
  logic                 stop;
  logic                 rd_inc;
  logic                 rd_dec;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [DATA_BITS-1:0] rd_data;
  logic [ADDR_BITS:0]   count;
  logic                 busy;
  logic                 done;

  modport master (
    output in_valid, in_data, start, stop, rd_inc, rd_dec,
    input  rd_addr, rd_data, count, busy, done
  );

  modport slave (
    input  in_valid, in_data, start, stop, rd_inc, rd_dec,
    output rd_addr, rd_data, count, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/result_capture_buffer_capture_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read, block-RAM friendly.
`default_nettype none

module result_capture_buffer_capture_ram #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; array contents stay undefined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/result_capture_buffer.sv
// Skips filter fill outputs, captures a run of samples to RAM, then exposes a button-driven wrap-around read pointer.
`default_nettype none

module result_capture_buffer
  import result_capture_buffer_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = DEFAULT_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst,
  result_capture_buffer_if.slave bus
);

  localparam int SKIP_BITS = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam int CNT_BITS  = ADDR_BITS + 1;
  localparam state_t RUN_STATE = (LATENCY == 0) ? CAPTURE : SKIP;

  state_t state, next_state;

  logic [SKIP_BITS-1:0] skip_cnt, skip_plus;
  logic [CNT_BITS-1:0]  count, count_plus, count_last;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 start_q, inc_q, dec_q;
  logic                 start_rise, inc_rise, dec_rise;
  logic                 wr_en, clear_run, skip_inc, cnt_inc, enter_done;

  assign start_rise = bus.start  & ~start_q;
  assign inc_rise   = bus.rd_inc & ~inc_q;
  assign dec_rise   = bus.rd_dec & ~dec_q;

  assign skip_plus  = skip_cnt + SKIP_BITS'(1);
  assign count_plus = count + CNT_BITS'(1);
  assign count_last = count - CNT_BITS'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    clear_run  = 1'b0;
    skip_inc   = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_rise) begin
          clear_run  = 1'b1;
          next_state = RUN_STATE;
        end
      end
      SKIP: begin
        if (bus.stop) begin
          next_state = DONE;
        end else if (bus.in_valid) begin
          skip_inc = 1'b1;
          if (skip_plus == SKIP_BITS'(LATENCY)) begin
            next_state = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        // A sample arriving alongside stop is still stored before finishing.
        if (bus.in_valid && (count < CNT_BITS'(DEPTH))) begin
          wr_en   = 1'b1;
          cnt_inc = 1'b1;
          if (count_plus == CNT_BITS'(DEPTH)) begin
            next_state = DONE;
          end
        end
        if (bus.stop) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
    enter_done = (next_state == DONE) && (state != DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q  <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      skip_cnt <= '0;
      count    <= '0;
      rd_addr  <= '0;
    end else begin
      start_q <= bus.start;
      inc_q   <= bus.rd_inc;
      dec_q   <= bus.rd_dec;

      if (clear_run) begin
        skip_cnt <= '0;
        count    <= '0;
      end else begin
        if (skip_inc) begin
          skip_cnt <= skip_plus;
        end
        if (cnt_inc) begin
          count <= count_plus;
        end
      end

      // Simultaneous inc and dec edges cancel; an empty capture pins the pointer at 0.
      if (enter_done) begin
        rd_addr <= '0;
      end else if ((state == DONE) && !clear_run && (count != '0) && (inc_rise ^ dec_rise)) begin
        if (inc_rise) begin
          rd_addr <= ({1'b0, rd_addr} == count_last) ? '0 : rd_addr + ADDR_BITS'(1);
        end else begin
          rd_addr <= (rd_addr == '0) ? count_last[ADDR_BITS-1:0] : rd_addr - ADDR_BITS'(1);
        end
      end
    end
  end

  result_capture_buffer_capture_ram #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_capture_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (count[ADDR_BITS-1:0]),
    .wr_data (bus.in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign bus.rd_addr = rd_addr;
  assign bus.rd_data = rd_data;
  assign bus.count   = count;
  assign bus.busy    = (state == SKIP) || (state == CAPTURE);
  assign bus.done    = (state == DONE);

endmodule

`default_nettype wire
